vga_fb_scheduler: RTL and testbench
===================================

Name: vga_fb_scheduler

Overview:
- Single-port scheduler for the 640x480x24-bit framebuffer RAM.
- Shares the RAM port between two requesters:
  - the display scan-out, which prefetches pixels in raster order into a small show-ahead FIFO;
  - a pixel-write requester (CPU/drawing engine) using a valid/ready handshake.
- Sits between vga_ctrl (pops one pixel per active cycle) and the framebuffer RAM.
- Replaces direct combinational indexing of the frame memory by vga_ctrl.

Parameters:
- H_RES, 640, pixels per line.
- V_RES, 480, lines per frame.
- DEPTH, 16, prefetch FIFO entries (power of two, >=4).
- LOW_WM, 4, fetch becomes urgent when credits < LOW_WM.
- STARVE_MAX, 8, cycles a pending write may lose arbitration before it is forced through.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- frame_start  in  1  one-cycle pulse at start of vertical blanking
- pix_pop  in  1  vga_ctrl consumes head pixel (driven by valid)
- pix_data  out  24  FIFO head pixel, {r,g,b}; 0 when FIFO empty
- underflow  out  1  one-cycle pulse: pix_pop while FIFO empty
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted this cycle
- wr_x  in  10  write column
- wr_y  in  10  write row
- wr_data  in  24  write pixel
- mem_en  out  1  RAM access this cycle
- mem_we  out  1  RAM write (valid with mem_en)
- mem_addr  out  19  RAM word address
- mem_wdata  out  24  RAM write data
- mem_rdata  in  24  RAM read data, valid 1 cycle after a read

Behaviour:
- Reset (clk edge with reset=1):
  - FIFO empty, fetch pointer 0, fetch_done 0, starve counter 0, no read in flight.
  - Outputs: pix_data 0, underflow 0, wr_ready 0, mem_en 0, mem_we 0, mem_addr 0, mem_wdata 0.
  - Fetching of frame 0 begins the cycle after reset deasserts.
- Address: y*H_RES + x, truncated to 19 bits. For the 640 default this is (y<<9)+(y<<7)+x.
- credits = FIFO level + reads in flight (0 or 1). A fetch is only issued if credits < DEPTH.
- Per-cycle grant, evaluated combinationally; the first matching rule wins:
  1. WRITE: wr_valid and starve counter == STARVE_MAX.
  2. FETCH: !fetch_done and credits < LOW_WM.
  3. WRITE: wr_valid.
  4. FETCH: !fetch_done and credits < DEPTH.
  5. IDLE otherwise.
- Write grant:
  - wr_ready=1 in that cycle.
  - If wr_x < H_RES and wr_y < V_RES: mem_en=1, mem_we=1.
  - Otherwise the write is accepted and dropped, with mem_en=0.
- Starve counter:
  - Increments (saturating at STARVE_MAX) each cycle wr_valid=1 and the write is not granted.
  - Clears on write grant or when wr_valid=0.
- Fetch grant:
  - mem_en=1, mem_we=0, mem_addr = fetch pointer.
  - Pointer increments; at H_RES*V_RES-1 it wraps to 0 and sets fetch_done.
- Read return: one cycle after a fetch, mem_rdata is pushed into the FIFO, unless it is tagged stale.
- FIFO behaviour:
  - Show-ahead: pix_data = head entry combinationally.
  - Push and pop in the same cycle keep the level unchanged.
  - Pop on empty: no state change, pix_data=0, underflow=1 for that cycle.
- frame_start:
  - Flushes the FIFO, sets the pointer to 0, clears fetch_done.
  - Marks any in-flight read stale; its data is discarded.
  - A pop in the same cycle is ignored.
  - A grant in that same cycle still executes, except that a fetch grant is suppressed.
- Reset mid-operation discards the in-flight read and any pending write (the write was never acknowledged).

Decomposition:
- Package fb_pkg:
  - H_RES, V_RES, PIX_W=24, ADDR_W=19.
  - grant_e {GNT_IDLE, GNT_FETCH, GNT_WRITE}.
  - Address function fb_addr(x,y).
- One sub-module: fb_pix_fifo.
  - Synchronous show-ahead FIFO, DEPTH x PIX_W.
  - Ports: push, pop, flush, level, head.
- Arbiter, pointer, starve counter and stale tag live in the top.

Test Plan:
- Reset release, no pops, RAM preloaded with addr value:
  - mem_en reads at addresses 0..15, one per cycle.
  - FIFO full at level 16; mem_en then stays 0.
  - pix_data=24'h000000 (addr 0 contents).
- Steady pop every cycle after fill:
  - pix_data sequence 0,1,2,...
  - Exactly one read per pop; underflow never pulses.
- Pop on empty (pix_pop=1 one cycle after reset) -> underflow=1 for one cycle, pix_data=0, no pointer change.
- With FIFO full, wr_valid x=3 y=2 data=24'hABCDEF:
  - Same cycle: wr_ready=1, mem_we=1, mem_addr=1283, mem_wdata=24'hABCDEF.
- Continuous pop keeping credits < LOW_WM while wr_valid held:
  - wr_ready rises on the 9th cycle of wr_valid (after 8 losses).
- frame_start while a fetch is in flight and the FIFO holds 10 entries:
  - Next cycle: FIFO empty, stale data not pushed.
  - Next fetch at mem_addr=0.
- Additional check: write with x=640 -> wr_ready=1, mem_en=0.

Source files
------------

// File: rtl/fb_pkg.sv
`default_nettype none
// ---- fb_pkg | framebuffer geometry, grant encoding, pixel address helper | rev 1.0 ----
package fb_pkg;

   localparam int H_RES  = 640;
   localparam int V_RES  = 480;
   localparam int PIX_W  = 24;
   localparam int ADDR_W = 19;

   typedef enum logic [1:0] {
      GNT_IDLE  = 2'd0,
      GNT_FETCH = 2'd1,
      GNT_WRITE = 2'd2
   } grant_e;

   // Row-major word address; the line width is passed in so a resized top stays consistent.
   function automatic logic [ADDR_W-1:0] fb_addr(input logic [9:0] x,
                                                 input logic [9:0] y,
                                                 input int         hres);
      return ADDR_W'(32'(y) * 32'(hres) + 32'(x));
   endfunction

endpackage
`default_nettype wire

// File: rtl/fb_pix_fifo.sv
`default_nettype none
// ---- fb_pix_fifo | synchronous show-ahead pixel FIFO with flush | rev 1.0 ----
module fb_pix_fifo
   import fb_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [PIX_W-1:0]       push_data,
   input  logic                   pop,
   input  logic                   flush,
   output logic [$clog2(DEPTH):0] level,
   output logic [PIX_W-1:0]       head
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [PIX_W-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LW-1:0]    count;
   logic             do_pop;
   logic             do_push;

   assign do_pop  = pop && (count != '0);
   // A full FIFO may still accept a push when the head leaves in the same cycle.
   assign do_push = push && ((count != LW'(DEPTH)) || do_pop);

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + LW'(do_push) - LW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush && !reset) mem[wr_ptr] <= push_data;
   end

   assign head  = (count == '0) ? '0 : mem[rd_ptr];
   assign level = count;

endmodule
`default_nettype wire

// File: rtl/vga_fb_scheduler.sv
`default_nettype none
// ---- vga_fb_scheduler | arbitrates the framebuffer RAM port between scan-out prefetch and pixel writes | rev 1.0 ----
module vga_fb_scheduler #(
   parameter int H_RES      = fb_pkg::H_RES,
   parameter int V_RES      = fb_pkg::V_RES,
   parameter int DEPTH      = 16,
   parameter int LOW_WM     = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        frame_start,
   input  logic                        pix_pop,
   output logic [fb_pkg::PIX_W-1:0]    pix_data,
   output logic                        underflow,
   input  logic                        wr_valid,
   output logic                        wr_ready,
   input  logic [9:0]                  wr_x,
   input  logic [9:0]                  wr_y,
   input  logic [fb_pkg::PIX_W-1:0]    wr_data,
   output logic                        mem_en,
   output logic                        mem_we,
   output logic [fb_pkg::ADDR_W-1:0]   mem_addr,
   output logic [fb_pkg::PIX_W-1:0]    mem_wdata,
   input  logic [fb_pkg::PIX_W-1:0]    mem_rdata
);

   import fb_pkg::*;

   localparam int LW = $clog2(DEPTH) + 1;
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

   logic [ADDR_W-1:0] fetch_ptr;
   logic              fetch_done;
   logic              rd_pending;
   logic [SW-1:0]     starve_cnt;
   logic [LW-1:0]     level;
   logic [LW-1:0]     credits;
   logic [PIX_W-1:0]  head;
   grant_e            grant;
   logic              wr_in_range;
   logic              fetch_go;
   logic              write_go;
   logic              fifo_push;
   logic              fifo_pop;

   assign credits     = level + LW'(rd_pending);
   assign wr_in_range = (int'(wr_x) < H_RES) && (int'(wr_y) < V_RES);

   always_comb begin
      grant = GNT_IDLE;
      if (reset)
         grant = GNT_IDLE;
      else if (wr_valid && (starve_cnt == SW'(STARVE_MAX)))
         grant = GNT_WRITE;
      else if (!fetch_done && (credits < LW'(LOW_WM)))
         grant = GNT_FETCH;
      else if (wr_valid)
         grant = GNT_WRITE;
      else if (!fetch_done && (credits < LW'(DEPTH)))
         grant = GNT_FETCH;
   end

   // A fetch winning arbitration on frame_start is dropped; the write still loses that cycle.
   assign fetch_go = (grant == GNT_FETCH) && !frame_start;
   assign write_go = (grant == GNT_WRITE) && wr_in_range;

   always_comb begin
      wr_ready  = (grant == GNT_WRITE);
      mem_en    = fetch_go || write_go;
      mem_we    = write_go;
      mem_addr  = '0;
      mem_wdata = '0;
      if (write_go) begin
         mem_addr  = fb_addr(wr_x, wr_y, H_RES);
         mem_wdata = wr_data;
      end else if (fetch_go) begin
         mem_addr  = fetch_ptr;
      end
   end

   // Read latency is one cycle, so a read returning during frame_start is the stale one.
   assign fifo_push = rd_pending && !frame_start;
   assign fifo_pop  = pix_pop && !frame_start && !reset;
   assign underflow = pix_pop && (level == '0) && !frame_start && !reset;
   assign pix_data  = head;

   fb_pix_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (fifo_push),
      .push_data(mem_rdata),
      .pop      (fifo_pop),
      .flush    (frame_start),
      .level    (level),
      .head     (head)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_ptr  <= '0;
         fetch_done <= 1'b0;
         rd_pending <= 1'b0;
         starve_cnt <= '0;
      end else begin
         rd_pending <= fetch_go;

         if (wr_valid && (grant != GNT_WRITE)) begin
            if (starve_cnt != SW'(STARVE_MAX)) starve_cnt <= starve_cnt + SW'(1);
         end else begin
            starve_cnt <= '0;
         end

         if (frame_start) begin
            fetch_ptr  <= '0;
            fetch_done <= 1'b0;
         end else if (fetch_go) begin
            if (fetch_ptr == LAST_ADDR) begin
               fetch_ptr  <= '0;
               fetch_done <= 1'b1;
            end else begin
               fetch_ptr  <= fetch_ptr + ADDR_W'(1);
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_scheduler.sv
`default_nettype none
// ---- tb_vga_fb_scheduler | self-checking bench: directed scenarios plus random traffic vs queue model | rev 1.0 ----
module tb_vga_fb_scheduler;

   localparam int HR   = 640;
   localparam int VR   = 480;
   localparam int DEP  = 16;
   localparam int LWM  = 4;
   localparam int SMAX = 8;
   localparam int LAST = HR * VR - 1;

   logic        clk = 1'b0;
   logic        reset, frame_start, pix_pop, wr_valid;
   logic [9:0]  wr_x, wr_y;
   logic [23:0] wr_data, pix_data, mem_wdata, mem_rdata;
   logic        underflow, wr_ready, mem_en, mem_we;
   logic [18:0] mem_addr;

   always #5 clk = ~clk;

   vga_fb_scheduler dut (
      .clk        (clk),
      .reset      (reset),
      .frame_start(frame_start),
      .pix_pop    (pix_pop),
      .pix_data   (pix_data),
      .underflow  (underflow),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_x       (wr_x),
      .wr_y       (wr_y),
      .wr_data    (wr_data),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   // RAM: unwritten words read back as their own address.
   logic [23:0] ram   [524288];
   bit          ram_w [524288];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            ram[mem_addr]   <= mem_wdata;
            ram_w[mem_addr] <= 1'b1;
         end else begin
            mem_rdata <= ram_w[mem_addr] ? ram[mem_addr] : 24'(mem_addr);
         end
      end
   end

   int n_checks = 0;
   int n_pass   = 0;
   int cyc_n    = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Reference model: pixel queue, fetch pointer, one pending read, starvation count.
   logic [23:0] q[$];
   int          m_ptr = 0;
   bit          m_done = 0;
   bit          m_pend = 0;
   logic [23:0] m_pend_val = '0;
   int          m_starve = 0;
   logic [23:0] m_wr [int];

   logic        obs_under, obs_ready, obs_en, obs_we;
   logic [23:0] obs_pix, obs_wd;
   logic [18:0] obs_addr;
   bit          last_ready = 0;

   function automatic logic [23:0] mdl_val(int a);
      return m_wr.exists(a) ? m_wr[a] : 24'(a);
   endfunction

   task automatic cyc(input bit r, input bit fs, input bit pp, input bit wv,
                      input logic [9:0] wx, input logic [9:0] wy, input logic [23:0] wd);
      int          credits;
      int          g;
      bit          inr, e_fetch, e_wr;
      int          e_addr;
      logic [23:0] e_pix;
      bit          e_under;
      reset = r; frame_start = fs; pix_pop = pp;
      wr_valid = wv; wr_x = wx; wr_y = wy; wr_data = wd;
      @(negedge clk);
      credits = q.size() + int'(m_pend);
      if (r)                                g = 0;
      else if (wv && m_starve == SMAX)      g = 2;
      else if (!m_done && credits < LWM)    g = 1;
      else if (wv)                          g = 2;
      else if (!m_done && credits < DEP)    g = 1;
      else                                  g = 0;
      inr     = (int'(wx) < HR) && (int'(wy) < VR);
      e_fetch = (g == 1) && !fs;
      e_wr    = (g == 2) && inr;
      e_addr  = e_wr ? int'(wy) * HR + int'(wx) : (e_fetch ? m_ptr : 0);
      e_under = pp && !fs && !r && (q.size() == 0);
      e_pix   = (q.size() != 0) ? q[0] : 24'h0;

      obs_under = underflow; obs_ready = wr_ready; obs_en = mem_en; obs_we = mem_we;
      obs_pix = pix_data; obs_wd = mem_wdata; obs_addr = mem_addr;

      if (!r) check($sformatf("pix_data@%0d", cyc_n), pix_data, e_pix);
      check($sformatf("underflow@%0d", cyc_n), underflow, e_under);
      check($sformatf("wr_ready@%0d", cyc_n), wr_ready, (g == 2));
      check($sformatf("mem_en@%0d", cyc_n), mem_en, e_fetch || e_wr);
      check($sformatf("mem_we@%0d", cyc_n), mem_we, e_wr);
      check($sformatf("mem_addr@%0d", cyc_n), mem_addr, e_addr);
      check($sformatf("mem_wdata@%0d", cyc_n), mem_wdata, e_wr ? wd : 24'h0);

      if (r) begin
         q.delete(); m_ptr = 0; m_done = 0; m_pend = 0; m_starve = 0;
      end else begin
         if (e_wr) m_wr[e_addr] = wd;
         m_starve = (wv && g != 2) ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
         if (fs) begin
            q.delete(); m_ptr = 0; m_done = 0; m_pend = 0;
         end else begin
            if (pp && q.size() != 0) void'(q.pop_front());
            if (m_pend) q.push_back(m_pend_val);
            m_pend = e_fetch;
            if (e_fetch) begin
               m_pend_val = mdl_val(m_ptr);
               if (m_ptr == LAST) begin m_ptr = 0; m_done = 1; end
               else m_ptr++;
            end
         end
      end
      last_ready = (g == 2);
      cyc_n++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int          reads;
      int          k;
      bit          cwv;
      logic [9:0]  cwx, cwy;
      logic [23:0] cwd;
      reset = 1; frame_start = 0; pix_pop = 0; wr_valid = 0;
      wr_x = '0; wr_y = '0; wr_data = '0;
      @(posedge clk); #1;
      repeat (3) cyc(1, 0, 0, 0, 0, 0, 0);

      // pop on empty right after reset; first fetch at address 0
      cyc(0, 0, 1, 0, 0, 0, 0);
      check("underflow_after_reset", obs_under, 1);
      check("pix_empty_zero", obs_pix, 0);
      check("first_fetch_addr", obs_addr, 0);
      check("first_fetch_en", obs_en, 1);

      repeat (20) cyc(0, 0, 0, 0, 0, 0, 0);
      check("idle_when_full", obs_en, 0);
      check("head_is_addr0", obs_pix, 0);

      cyc(0, 0, 0, 1, 10'd3, 10'd2, 24'hABCDEF);
      check("wr_ready_full", obs_ready, 1);
      check("wr_we_full", obs_we, 1);
      check("wr_addr_1283", obs_addr, 1283);
      check("wr_wdata", obs_wd, 24'hABCDEF);

      cyc(0, 0, 0, 1, 10'd640, 10'd5, 24'h123456);
      check("oob_ready", obs_ready, 1);
      check("oob_mem_en", obs_en, 0);

      reads = 0;
      for (int i = 0; i < 40; i++) begin
         cyc(0, 0, 1, 0, 0, 0, 0);
         check($sformatf("pop_seq_%0d", i), obs_pix, i);
         check($sformatf("pop_no_underflow_%0d", i), obs_under, 0);
         reads += int'(obs_en);
      end
      cyc(0, 0, 0, 0, 0, 0, 0);
      reads += int'(obs_en);
      check("reads_per_pop", reads, 40);

      // starvation: urgent fetching beats the write until it has lost STARVE_MAX times
      repeat (2) cyc(1, 0, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 9; i++) begin
         cyc(0, 0, 1, 1, 10'd7, 10'd7, 24'h0F0F0F);
         check($sformatf("starve_ready_c%0d", i), obs_ready, (i == 9));
      end

      // frame_start with a read in flight and 10 pixels queued
      repeat (2) cyc(1, 0, 0, 0, 0, 0, 0);
      k = 0;
      while (!(q.size() == 10 && m_pend) && k < 50) begin
         cyc(0, 0, 0, 0, 0, 0, 0);
         k++;
      end
      check("fs_setup_reached", (k < 50), 1);
      cyc(0, 1, 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0, 0);
      check("fs_fifo_empty_pix", obs_pix, 0);
      check("fs_fifo_empty_underflow", obs_under, 1);
      check("fs_refetch_addr0", obs_addr, 0);
      check("fs_refetch_en", obs_en, 1);

      // random traffic; a write request is held until accepted
      cwv = 0; cwx = '0; cwy = '0; cwd = '0;
      for (int i = 0; i < 3000; i++) begin
         bit r, fs, pp;
         r  = ($urandom_range(0, 499) == 0);
         fs = ($urandom_range(0, 199) == 0);
         pp = ($urandom_range(0, 99) < 55);
         if (!cwv || last_ready) begin
            cwv = ($urandom_range(0, 99) < 40);
            cwx = 10'($urandom_range(0, 700));
            cwy = 10'($urandom_range(0, 520));
            cwd = 24'($urandom);
         end
         cyc(r, fs, pp, cwv, cwx, cwy, cwd);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
